// File: rtl/stack_drain_pkg.sv
// Shared types and constants for the stack drain reader.
package stack_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } drain_state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/stack_drain_if.sv
// Valid/ready output stream of the stack drain reader.
interface stack_drain_if #(
  parameter int bW = 8
);
  logic [bW-1:0] outData;
  logic          outValid;
  logic          outReady;

  modport master (output outData, output outValid, input outReady);
  modport slave  (input outData, input outValid, output outReady);
endinterface

// File: rtl/stack_drain_skid_buf2.sv
// Two-entry FIFO-ordered skid buffer; head entry drives the output stream.
module skid_buf2 #(
  parameter int bW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [bW-1:0] inData,
  input  logic          inValid,
  output logic [bW-1:0] outData,
  output logic          outValid,
  input  logic          outReady,
  output logic [1:0]    occ
);

  logic [bW-1:0] d0_q, d1_q;
  logic [1:0]    occ_q;
  logic          enq, deq;
  logic [1:0]    wslot;

  assign deq   = (occ_q != 2'd0) && outReady;
  assign enq   = inValid && ((occ_q != 2'd2) || deq);
  // A write lands behind whatever survives this cycle's dequeue
  assign wslot = occ_q - {1'b0, deq};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_q  <= '0;
      d1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      if (deq) d0_q <= d1_q;
      if (enq) begin
        if (wslot == 2'd0) d0_q <= inData;
        else               d1_q <= inData;
      end
      occ_q <= occ_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  assign outData  = d0_q;
  assign outValid = (occ_q != 2'd0);
  assign occ      = occ_q;

endmodule

// File: rtl/stack_drain.sv
// Pops up to len entries from a lifo and streams them out top first through a skid buffer.
// Optional pop counter port is enabled by defining STACK_DRAIN_CNT_EN.
module stack_drain
  import stack_drain_pkg::*;
#(
  parameter  int bW = 8,
  parameter  int eC = 16,
  localparam int cW = $clog2(eC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [cW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          pop,
  input  logic [bW-1:0] popData,
  input  logic          empty,
  stack_drain_if.master strm
`ifdef STACK_DRAIN_CNT_EN
  ,
  output logic [cW-1:0] count
`endif
);

  drain_state_t  state_q, state_d;
  logic [cW-1:0] rem_q;
  logic [1:0]    occ;
  logic [bW-1:0] buf_data;
  logic          buf_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // pop is built only from registered terms and empty, so outReady never reaches it
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    pop     = (state_q == DRAIN) && !empty && (rem_q != '0) && (occ < 2'(SKID_DEPTH));
    case (state_q)
      IDLE:  if (start) state_d = (len == '0) ? FLUSH : DRAIN;
      DRAIN: if ((rem_q == '0) || empty || (pop && (rem_q == cW'(1)))) state_d = FLUSH;
      FLUSH: if (occ == 2'd0) begin
        state_d = IDLE;
        done    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          rem_q <= '0;
    else if ((state_q == IDLE) && start) rem_q <= len;
    else if (pop)                     rem_q <= rem_q - cW'(1);
  end

`ifdef STACK_DRAIN_CNT_EN
  logic [cW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          count_q <= '0;
    else if ((state_q == IDLE) && start) count_q <= '0;
    else if (pop)                     count_q <= count_q + cW'(1);
  end

  assign count = count_q;
`endif

  skid_buf2 #(.bW(bW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .inData   (popData),
    .inValid  (pop),
    .outData  (buf_data),
    .outValid (buf_valid),
    .outReady (strm.outReady),
    .occ      (occ)
  );

  assign strm.outData  = buf_data;
  assign strm.outValid = buf_valid;

endmodule

// File: tb/tb_stack_drain.sv
// Bench for stack_drain paired with a behavioural lifo; expected words come from a queue model of the stack.
module tb_stack_drain;
  localparam int BW = 8;
  localparam int EC = 16;
  localparam int CW = $clog2(EC + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          busy, done, pop, empty;
  logic [BW-1:0] popData;
`ifdef STACK_DRAIN_CNT_EN
  logic [CW-1:0] count;
`endif

  stack_drain_if #(.bW(BW)) strm ();

  stack_drain #(.bW(BW), .eC(EC)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .busy    (busy),
    .done    (done),
    .pop     (pop),
    .popData (popData),
    .empty   (empty),
    .strm    (strm)
`ifdef STACK_DRAIN_CNT_EN
    ,
    .count   (count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // behavioural lifo
  logic [BW-1:0] mem [0:EC-1];
  int            sp = 0;
  logic          push_en = 1'b0;
  logic [BW-1:0] push_val = '0;

  assign empty   = (sp == 0);
  assign popData = empty ? '0 : mem[sp-1];

  always @(posedge clk) begin
    if (pop && sp > 0) sp <= sp - 1;
    else if (push_en && sp < EC) begin
      mem[sp] <= push_val;
      sp      <= sp + 1;
    end
  end

  // stream monitor with cumulative counters
  int            cyc = 0;
  logic [BW-1:0] got_q[$];
  int            xfer_cyc[$];
  int            done_cnt = 0, pop_cnt = 0, stab_err = 0, pop_empty_err = 0;
  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [BW-1:0] prev_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) prev_v = 1'b0;
    else begin
      if (prev_v && !prev_r && (!strm.outValid || strm.outData != prev_d)) stab_err++;
      if (strm.outValid && strm.outReady) begin
        got_q.push_back(strm.outData);
        xfer_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      if (pop) pop_cnt++;
      if (pop && empty) pop_empty_err++;
      prev_v = strm.outValid;
      prev_r = strm.outReady;
      prev_d = strm.outData;
    end
  end

  // reference: stack contents, bottom at index 0
  logic [BW-1:0] ref_q[$];
  logic [BW-1:0] exp_q[$];
  int            g0, d0, p0;

  task automatic push_word(input logic [BW-1:0] v);
    @(posedge clk); #1;
    push_en  = 1'b1;
    push_val = v;
    ref_q.push_back(v);
    @(posedge clk); #1;
    push_en = 1'b0;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push_word(BW'($urandom));
  endtask

  task automatic begin_drain(input int n);
    int k;
    exp_q.delete();
    k = (n < ref_q.size()) ? n : ref_q.size();
    for (int i = 0; i < k; i++) exp_q.push_back(ref_q.pop_back());
    g0 = got_q.size();
    d0 = done_cnt;
    p0 = pop_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len   = CW'(n);
    @(posedge clk); #1;
    start = 1'b0;
    len   = CW'($urandom_range(0, EC));
  endtask

  task automatic wait_drain(input string tag, input int rdy_pct, input bit busy_start);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_cnt != d0 && !busy) begin
        ok = 1'b1;
        break;
      end
      if (busy_start && c == 1 && busy) begin
        start = 1'b1;
        len   = CW'($urandom_range(1, EC));
      end
      strm.outReady = ($urandom_range(1, 100) <= rdy_pct);
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_finished"}, ok, 1);
    chk({tag, "_ndone"}, done_cnt - d0, 1);
    chk({tag, "_nwords"}, got_q.size() - g0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (g0 + i < got_q.size()) chk($sformatf("%s_word%0d", tag, i), got_q[g0+i], exp_q[i]);
    chk({tag, "_npops"}, pop_cnt - p0, exp_q.size());
    chk({tag, "_lifo_occ"}, sp, ref_q.size());
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_pop_empty"}, pop_empty_err, 0);
    chk({tag, "_busy"}, busy, 0);
`ifdef STACK_DRAIN_CNT_EN
    chk({tag, "_count"}, count, exp_q.size());
`endif
  endtask

  initial begin
    strm.outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pop", pop, 0);
    chk("rst_valid", strm.outValid, 0);
    chk("rst_data", strm.outData, 0);
`ifdef STACK_DRAIN_CNT_EN
    chk("rst_count", count, 0);
`endif
    rst = 1'b0;

    // top first, back to back
    strm.outReady = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    begin_drain(3);
    wait_drain("basic", 100, 1'b0);
    chk("basic_consec", (got_q.size() >= g0 + 3) ? xfer_cyc[g0+2] - xfer_cyc[g0] : -1, 2);
    chk("basic_empty", empty, 1);

    // partial drain
    push_rand(5);
    begin_drain(2);
    wait_drain("partial", 100, 1'b0);
    chk("partial_left", sp, 3);
    begin_drain(EC);
    wait_drain("clear", 70, 1'b0);

    // stack runs dry
    push_rand(2);
    begin_drain(5);
    wait_drain("early", 100, 1'b0);

    // back pressure
    push_rand(4);
    strm.outReady = 1'b0;
    begin_drain(4);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_pops", pop_cnt - p0, 2);
    chk("stall_valid", strm.outValid, 1);
    chk("stall_head", strm.outData, exp_q[0]);
    wait_drain("stall", 100, 1'b0);

    // zero length, then start while busy
    push_rand(3);
    begin_drain(0);
    wait_drain("len0", 100, 1'b0);
    begin_drain(3);
    wait_drain("busystart", 60, 1'b1);

    // reset mid-drain with two words buffered
    push_rand(6);
    strm.outReady = 1'b0;
    begin_drain(6);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_pops", pop_cnt - p0, 2);
    rst = 1'b1;
    #1;
    chk("mrst_valid", strm.outValid, 0);
    chk("mrst_busy", busy, 0);
    for (int i = exp_q.size() - 1; i >= 2; i--) ref_q.push_back(exp_q[i]);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_lifo", sp, ref_q.size());
    begin_drain(EC);
    wait_drain("after_rst", 100, 1'b0);

    // randomized drains
    for (int it = 0; it < 15; it++) begin
      push_rand($urandom_range(0, EC - ref_q.size()));
      begin_drain($urandom_range(0, EC));
      wait_drain($sformatf("rnd%0d", it), $urandom_range(30, 100), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
